// File: rtl/hood_mode_controller.sv
// Range-hood master state machine: button-driven mode selection plus
// hurricane, delayed-standby and self-clean countdowns on a 1 Hz tick.
module hood_mode_controller #(
   parameter int unsigned HURRICANE_SEC = 60,
   parameter int unsigned WAIT_SEC      = 60,
   parameter int unsigned CLEAN_SEC     = 180,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_1s,
   input  logic             btn_power,
   input  logic             btn_menu,
   input  logic             btn_level1,
   input  logic             btn_level2,
   input  logic             btn_level3,
   input  logic             btn_clean,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] countdown,
   output logic             hurricane_used
);

   localparam logic [CNT_W-1:0] HURRICANE_LOAD = CNT_W'(HURRICANE_SEC);
   localparam logic [CNT_W-1:0] WAIT_LOAD      = CNT_W'(WAIT_SEC);
   localparam logic [CNT_W-1:0] CLEAN_LOAD     = CNT_W'(CLEAN_SEC);
   localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

   typedef enum logic [2:0] {
      S_OFF          = 3'b000,
      S_STANDBY      = 3'b001,
      S_MODE_SELECT  = 3'b010,
      S_FIRST_LEVEL  = 3'b011,
      S_SECOND_LEVEL = 3'b100,
      S_THIRD_LEVEL  = 3'b101,
      S_SELF_CLEAN   = 3'b110,
      S_WAIT_STANDBY = 3'b111
   } state_t;

   state_t           state_q, state_d;
   state_t           target;
   logic             take;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hu_q, hu_d;

   // State, countdown and session flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         hu_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hu_q    <= hu_d;
      end
   end

   // Button arbitration: first legal button in priority order wins
   always_comb begin
      take   = 1'b0;
      target = state_q;
      if (btn_power) begin
         take   = 1'b1;
         target = (state_q == S_OFF) ? S_STANDBY : S_OFF;
      end else begin
         case (state_q)
            S_STANDBY: begin
               if (btn_menu) begin
                  take   = 1'b1;
                  target = S_MODE_SELECT;
               end
            end
            S_MODE_SELECT: begin
               if (btn_menu) begin
                  take   = 1'b1;
                  target = S_STANDBY;
               end else if (btn_clean) begin
                  take   = 1'b1;
                  target = S_SELF_CLEAN;
               end else if (btn_level3 && !hu_q) begin
                  take   = 1'b1;
                  target = S_THIRD_LEVEL;
               end else if (btn_level2) begin
                  take   = 1'b1;
                  target = S_SECOND_LEVEL;
               end else if (btn_level1) begin
                  take   = 1'b1;
                  target = S_FIRST_LEVEL;
               end
            end
            S_FIRST_LEVEL, S_SECOND_LEVEL: begin
               if (btn_menu) begin
                  take   = 1'b1;
                  target = S_STANDBY;
               end else if (btn_level3 && !hu_q) begin
                  take   = 1'b1;
                  target = S_THIRD_LEVEL;
               end else if (btn_level2) begin
                  take   = 1'b1;
                  target = S_SECOND_LEVEL;
               end else if (btn_level1) begin
                  take   = 1'b1;
                  target = S_FIRST_LEVEL;
               end
            end
            S_THIRD_LEVEL: begin
               if (btn_menu) begin
                  take   = 1'b1;
                  target = S_WAIT_STANDBY;
               end
            end
            S_OFF, S_SELF_CLEAN, S_WAIT_STANDBY: begin
               take   = 1'b0;
               target = state_q;
            end
         endcase
      end
   end

   // Next state: a button transition beats a same-cycle tick
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hu_d    = hu_q;
      if (take) begin
         state_d = target;
         case (target)
            S_THIRD_LEVEL:  cnt_d = HURRICANE_LOAD;
            S_SELF_CLEAN:   cnt_d = CLEAN_LOAD;
            S_WAIT_STANDBY: cnt_d = WAIT_LOAD;
            default:        cnt_d = '0;
         endcase
         if (target == S_OFF) begin
            hu_d = 1'b0;
         end else if (target == S_THIRD_LEVEL) begin
            hu_d = 1'b1;
         end
      end else if (tick_1s && (state_q == S_THIRD_LEVEL || state_q == S_SELF_CLEAN ||
                               state_q == S_WAIT_STANDBY)) begin
         if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            cnt_d   = '0;
            state_d = (state_q == S_THIRD_LEVEL) ? S_SECOND_LEVEL : S_STANDBY;
         end
      end
   end

   assign state          = state_q;
   assign countdown      = cnt_q;
   assign hurricane_used = hu_q;

endmodule

// File: tb/tb_hood_mode_controller.sv
// Bench for hood_mode_controller: directed scenarios plus randomized
// button/tick traffic checked against a rule-level reference model.
module tb_hood_mode_controller;

   localparam int unsigned H_SEC = 3;
   localparam int unsigned W_SEC = 4;
   localparam int unsigned C_SEC = 5;
   localparam int unsigned CW    = 8;

   localparam logic [7:0] B_RST   = 8'h80;
   localparam logic [7:0] B_PWR   = 8'h40;
   localparam logic [7:0] B_MENU  = 8'h20;
   localparam logic [7:0] B_CLEAN = 8'h10;
   localparam logic [7:0] B_L3    = 8'h08;
   localparam logic [7:0] B_L2    = 8'h04;
   localparam logic [7:0] B_L1    = 8'h02;
   localparam logic [7:0] B_TICK  = 8'h01;

   logic          clk = 1'b0;
   logic          rst = 1'b0, tick_1s = 1'b0;
   logic          btn_power = 1'b0, btn_menu = 1'b0, btn_level1 = 1'b0;
   logic          btn_level2 = 1'b0, btn_level3 = 1'b0, btn_clean = 1'b0;
   logic [2:0]    state;
   logic [CW-1:0] countdown;
   logic          hurricane_used;

   int tests_run = 0;
   int failed    = 0;

   // Reference model state: numeric state codes, seconds remaining, flag
   int m_state = 0;
   int m_cnt   = 0;
   bit m_hu    = 1'b0;

   hood_mode_controller #(
      .HURRICANE_SEC(H_SEC), .WAIT_SEC(W_SEC), .CLEAN_SEC(C_SEC), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .tick_1s(tick_1s),
      .btn_power(btn_power), .btn_menu(btn_menu), .btn_level1(btn_level1),
      .btn_level2(btn_level2), .btn_level3(btn_level3), .btn_clean(btn_clean),
      .state(state), .countdown(countdown), .hurricane_used(hurricane_used)
   );

   always #5 clk = ~clk;

   // Button b (0=power,1=menu,2=clean,3=level3,4=level2,5=level1) in state s:
   // destination state, or -1 if the button is ignored there.
   function automatic int dest(int s, int b, bit hu);
      if (b == 0) return (s == 0) ? 1 : 0;
      if (s == 1) return (b == 1) ? 2 : -1;
      if (s == 2 || s == 3 || s == 4) begin
         if (b == 1) return 1;
         if (b == 2) return (s == 2) ? 6 : -1;
         if (b == 3) return hu ? -1 : 5;
         if (b == 4) return 4;
         if (b == 5) return 3;
      end
      if (s == 5) return (b == 1) ? 7 : -1;
      return -1;
   endfunction

   function automatic int load_of(int s);
      if (s == 5) return int'(H_SEC);
      if (s == 6) return int'(C_SEC);
      if (s == 7) return int'(W_SEC);
      return 0;
   endfunction

   // One clock with the given pulses; model advances on the same edge
   task automatic apply(input logic [7:0] v);
      bit pressed [6];
      int d;
      bit acted;
      @(negedge clk);
      rst = v[7]; btn_power = v[6]; btn_menu = v[5]; btn_clean = v[4];
      btn_level3 = v[3]; btn_level2 = v[2]; btn_level1 = v[1]; tick_1s = v[0];
      pressed = '{v[6], v[5], v[4], v[3], v[2], v[1]};
      @(posedge clk);
      if (v[7]) begin
         m_state = 0; m_cnt = 0; m_hu = 1'b0;
      end else begin
         acted = 1'b0;
         for (int b = 0; b < 6; b++) begin
            if (!acted && pressed[b]) begin
               d = dest(m_state, b, m_hu);
               if (d >= 0) begin
                  acted = 1'b1;
                  m_state = d;
                  m_cnt = load_of(d);
                  if (d == 0) m_hu = 1'b0;
                  if (d == 5) m_hu = 1'b1;
               end
            end
         end
         if (!acted && v[0] && m_state >= 5) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else begin
               m_cnt = 0;
               m_state = (m_state == 5) ? 4 : 1;
            end
         end
      end
      #1;
      rst = 0; btn_power = 0; btn_menu = 0; btn_clean = 0;
      btn_level3 = 0; btn_level2 = 0; btn_level1 = 0; tick_1s = 0;
   endtask

   task automatic test_reset();
      apply(B_RST | B_PWR);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd0, 8'd0, 1'b0}) begin
         failed++; $display("FAIL reset: got s=%0d c=%0d h=%0b want 0/0/0", state, countdown, hurricane_used);
      end
   endtask

   task automatic test_hurricane();
      logic [11:0] exp [6];
      logic [7:0]  stim [6];
      stim = '{B_PWR, B_MENU, B_L3, B_TICK, B_TICK, B_TICK};
      exp  = '{{3'd1, 8'd0, 1'b0}, {3'd2, 8'd0, 1'b0}, {3'd5, 8'd3, 1'b1},
               {3'd5, 8'd2, 1'b1}, {3'd5, 8'd1, 1'b1}, {3'd4, 8'd0, 1'b1}};
      for (int i = 0; i < 6; i++) begin
         apply(stim[i]);
         tests_run++;
         if ({state, countdown, hurricane_used} !== exp[i]) begin
            failed++; $display("FAIL hurricane step %0d: got %h want %h", i, {state, countdown, hurricane_used}, exp[i]);
         end
      end
   endtask

   task automatic test_lockout();
      logic [11:0] exp [8];
      logic [7:0]  stim [8];
      stim = '{B_L3, B_MENU, B_MENU, B_L3, B_PWR, B_PWR, B_MENU, B_L3};
      exp  = '{{3'd4, 8'd0, 1'b1}, {3'd1, 8'd0, 1'b1}, {3'd2, 8'd0, 1'b1}, {3'd2, 8'd0, 1'b1},
               {3'd0, 8'd0, 1'b0}, {3'd1, 8'd0, 1'b0}, {3'd2, 8'd0, 1'b0}, {3'd5, 8'd3, 1'b1}};
      for (int i = 0; i < 8; i++) begin
         apply(stim[i]);
         tests_run++;
         if ({state, countdown, hurricane_used} !== exp[i]) begin
            failed++; $display("FAIL lockout step %0d: got %h want %h", i, {state, countdown, hurricane_used}, exp[i]);
         end
      end
   endtask

   task automatic test_wait_standby();
      apply(B_TICK);
      apply(B_MENU);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd7, 8'd4, 1'b1}) begin
         failed++; $display("FAIL wait_entry: got %h want %h", {state, countdown, hurricane_used}, {3'd7, 8'd4, 1'b1});
      end
      apply(B_L1 | B_L3 | B_CLEAN);
      apply(B_TICK); apply(B_TICK); apply(B_TICK);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd7, 8'd1, 1'b1}) begin
         failed++; $display("FAIL wait_count: got %h want %h", {state, countdown, hurricane_used}, {3'd7, 8'd1, 1'b1});
      end
      apply(B_TICK);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd1, 8'd0, 1'b1}) begin
         failed++; $display("FAIL wait_expire: got %h want %h", {state, countdown, hurricane_used}, {3'd1, 8'd0, 1'b1});
      end
      apply(B_TICK);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd1, 8'd0, 1'b1}) begin
         failed++; $display("FAIL standby_tick: got %h want %h", {state, countdown, hurricane_used}, {3'd1, 8'd0, 1'b1});
      end
   endtask

   task automatic test_self_clean();
      apply(B_MENU);
      apply(B_CLEAN);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd6, 8'd5, 1'b1}) begin
         failed++; $display("FAIL clean_entry: got %h want %h", {state, countdown, hurricane_used}, {3'd6, 8'd5, 1'b1});
      end
      apply(B_L1); apply(B_MENU);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd6, 8'd5, 1'b1}) begin
         failed++; $display("FAIL clean_ignore: got %h want %h", {state, countdown, hurricane_used}, {3'd6, 8'd5, 1'b1});
      end
      apply(B_TICK); apply(B_TICK);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd6, 8'd3, 1'b1}) begin
         failed++; $display("FAIL clean_count: got %h want %h", {state, countdown, hurricane_used}, {3'd6, 8'd3, 1'b1});
      end
      apply(B_PWR);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd0, 8'd0, 1'b0}) begin
         failed++; $display("FAIL clean_power: got %h want %h", {state, countdown, hurricane_used}, {3'd0, 8'd0, 1'b0});
      end
   endtask

   task automatic test_tick_vs_button();
      apply(B_PWR); apply(B_MENU); apply(B_L3); apply(B_TICK); apply(B_TICK);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd5, 8'd1, 1'b1}) begin
         failed++; $display("FAIL tvb_setup: got %h want %h", {state, countdown, hurricane_used}, {3'd5, 8'd1, 1'b1});
      end
      apply(B_MENU | B_TICK);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd7, 8'd4, 1'b1}) begin
         failed++; $display("FAIL tick_vs_button: got %h want %h", {state, countdown, hurricane_used}, {3'd7, 8'd4, 1'b1});
      end
   endtask

   task automatic test_priority();
      logic [11:0] exp [7];
      logic [7:0]  stim [7];
      stim = '{B_PWR | B_MENU | B_TICK, B_PWR | B_MENU, B_MENU | B_L1, B_CLEAN | B_L3 | B_L2,
               B_PWR | B_CLEAN, B_PWR, B_MENU};
      exp  = '{{3'd0, 8'd0, 1'b0}, {3'd1, 8'd0, 1'b0}, {3'd2, 8'd0, 1'b0}, {3'd6, 8'd5, 1'b0},
               {3'd0, 8'd0, 1'b0}, {3'd1, 8'd0, 1'b0}, {3'd2, 8'd0, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         apply(stim[i]);
         tests_run++;
         if ({state, countdown, hurricane_used} !== exp[i]) begin
            failed++; $display("FAIL priority step %0d: got %h want %h", i, {state, countdown, hurricane_used}, exp[i]);
         end
      end
      apply(B_L1 | B_L2);
      apply(B_CLEAN | B_L1);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd3, 8'd0, 1'b0}) begin
         failed++; $display("FAIL priority_clean_illegal: got %h want %h", {state, countdown, hurricane_used}, {3'd3, 8'd0, 1'b0});
      end
      apply(B_L3 | B_L2 | B_L1);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd5, 8'd3, 1'b1}) begin
         failed++; $display("FAIL priority_level3: got %h want %h", {state, countdown, hurricane_used}, {3'd5, 8'd3, 1'b1});
      end
   endtask

   task automatic test_reset_mid_count();
      apply(B_MENU);
      apply(B_TICK); apply(B_TICK); apply(B_TICK); apply(B_TICK);
      apply(B_MENU); apply(B_CLEAN); apply(B_TICK);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd6, 8'd4, 1'b1}) begin
         failed++; $display("FAIL rst_mid_setup: got %h want %h", {state, countdown, hurricane_used}, {3'd6, 8'd4, 1'b1});
      end
      apply(B_RST | B_L2);
      tests_run++;
      if ({state, countdown, hurricane_used} !== {3'd0, 8'd0, 1'b0}) begin
         failed++; $display("FAIL rst_mid: got %h want %h", {state, countdown, hurricane_used}, {3'd0, 8'd0, 1'b0});
      end
   endtask

   task automatic test_random();
      logic [7:0] v;
      for (int n = 0; n < 3000; n++) begin
         v = '0;
         v[7] = ($urandom_range(0, 199) == 0);
         v[6] = ($urandom_range(0, 29) == 0);
         for (int b = 1; b < 6; b++) v[b] = ($urandom_range(0, 5) == 0);
         v[0] = ($urandom_range(0, 2) == 0);
         apply(v);
         tests_run++;
         if ({state, countdown, hurricane_used} !== {3'(m_state), 8'(m_cnt), m_hu}) begin
            failed++;
            $display("FAIL random cycle %0d stim=%h: got s=%0d c=%0d h=%0b want s=%0d c=%0d h=%0b",
                     n, v, state, countdown, hurricane_used, m_state, m_cnt, m_hu);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hurricane();
      test_lockout();
      test_wait_standby();
      test_self_clean();
      test_tick_vs_button();
      test_priority();
      test_reset_mid_count();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/hood_mode_controller.md
Name: hood_mode_controller

Overview:
- Master state machine for the range-hood control path. It generates the 3-bit operating state that the power-state indicator decodes.
- Inputs are debounced single-cycle button pulses and a 1 Hz tick enable. It also runs the countdowns for hurricane (third level), delayed shutdown to standby, and self-clean.
- Outputs are the current state and the remaining countdown seconds, which feed the display and fan/LED drivers.

Parameters:
- HURRICANE_SEC, 60, seconds spent in THIRD_LEVEL before automatic fall-back to SECOND_LEVEL
- WAIT_SEC, 60, seconds in WAIT_TO_STANDBY before entering STANDBY
- CLEAN_SEC, 180, seconds in SELF_CLEAN before entering STANDBY
- CNT_W, 8, countdown width; must hold the largest of the three values above

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1s  in  1  one-cycle pulse once per second
- btn_power  in  1  debounced one-cycle pulse
- btn_menu  in  1  debounced one-cycle pulse
- btn_level1  in  1  debounced one-cycle pulse
- btn_level2  in  1  debounced one-cycle pulse
- btn_level3  in  1  debounced one-cycle pulse
- btn_clean  in  1  debounced one-cycle pulse
- state  out  3  OFF=000, STANDBY=001, MODE_SELECT=010, FIRST_LEVEL=011, SECOND_LEVEL=100, THIRD_LEVEL=101, SELF_CLEAN=110, WAIT_TO_STANDBY=111
- countdown  out  CNT_W  remaining seconds; 0 in non-timed states
- hurricane_used  out  1  high once THIRD_LEVEL has been entered in the current power session

Behaviour:
- All outputs are registered. A state change is visible on the cycle after the triggering pulse.
- Reset (synchronous, rst=1 at clk edge) sets state=OFF, countdown=0 and hurricane_used=0. It overrides every input and applies mid-countdown.
- Button priority when several pulse in the same cycle: power > menu > clean > level3 > level2 > level1. Only the highest-priority button that is legal in the current state acts.
- btn_power in any state other than OFF goes to OFF and clears countdown and hurricane_used.
- btn_power in OFF goes to STANDBY.
- STANDBY: menu goes to MODE_SELECT; all other buttons are ignored.
- MODE_SELECT:
  - menu goes to STANDBY.
  - level1 goes to FIRST_LEVEL; level2 goes to SECOND_LEVEL.
  - level3 goes to THIRD_LEVEL, but only when hurricane_used=0; otherwise it is ignored.
  - clean goes to SELF_CLEAN.
- FIRST_LEVEL / SECOND_LEVEL:
  - level1 and level2 switch directly between the two levels.
  - level3 goes to THIRD_LEVEL only when hurricane_used=0.
  - menu goes to STANDBY.
  - clean is ignored.
- THIRD_LEVEL:
  - Entry loads countdown=HURRICANE_SEC and sets hurricane_used=1.
  - menu goes to WAIT_TO_STANDBY and loads WAIT_SEC.
  - level1/level2/level3/clean are ignored.
- SELF_CLEAN: entry loads CLEAN_SEC. Only btn_power acts.
- WAIT_TO_STANDBY: entry loads WAIT_SEC. Only btn_power acts.
- Countdown rule for timed states:
  - On tick_1s with countdown>1, decrement by 1.
  - On tick_1s with countdown==1, expire: countdown becomes 0 and the state transitions on the same edge.
    - THIRD_LEVEL expires to SECOND_LEVEL.
    - SELF_CLEAN and WAIT_TO_STANDBY expire to STANDBY.
- A button transition and tick_1s in the same cycle: the button wins. The new state's load value (or 0) is written and the tick is discarded.
- Entering a non-timed state forces countdown=0. tick_1s has no effect in non-timed states.
- hurricane_used is cleared only by reset or entering OFF. It survives STANDBY, MODE_SELECT and SELF_CLEAN.
- No illegal encodings exist (all 8 are used); no default recovery path is needed beyond the case coverage.

Test Plan:
- Set HURRICANE_SEC=3. Apply rst, then power, menu, level3, then 3 ticks → state follows 000, 001, 010, 101 with countdown=3. Ticks give countdown 2, 1, then state=100 with countdown=0. hurricane_used=1.
- After the previous scenario, press level3 in SECOND_LEVEL → state stays 100. Press menu, menu, level3 → state=010 and level3 is ignored. Press power twice, menu, level3 → state=101 (flag cleared by OFF).
- In THIRD_LEVEL with countdown=2, press menu → state=111 with countdown=WAIT_SEC. After WAIT_SEC ticks → state=001 with countdown=0.
- Set CLEAN_SEC=5. From MODE_SELECT press clean → state=110, countdown=5. Press level1/menu → no change. After 2 ticks countdown=3; press power → state=000, countdown=0.
- Pulse btn_menu and tick_1s in the same cycle in THIRD_LEVEL with countdown=1 → state=111 with countdown=WAIT_SEC (no expiry to SECOND_LEVEL).
- Assert rst in SELF_CLEAN with countdown=4, together with btn_level2 → next cycle state=000, countdown=0, hurricane_used=0.
